// File: rtl/accum_frame.sv
// accum_frame: accumulates N 4-bit operands through a fadd_4 instance and
// presents the frame's 8-bit total {carry_cnt, acc} on an output handshake.
//   clk, rst_n            clock, async active-low reset
//   in_data/in_valid/in_ready     operand stream (valid/ready)
//   out_total/out_ovf/out_valid/out_ready  frame result (valid/ready)

// fadd_4: 4-bit adder, result wraps modulo 16.
module fadd_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] r
);
   assign r = a + b;
endmodule

module accum_frame #(
   parameter int unsigned N = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_total,
   output logic       out_ovf,
   output logic       out_valid,
   input  logic       out_ready
);
   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t        state, state_nxt;
   logic [3:0]    acc;
   logic [3:0]    carry_cnt;
   logic [CW-1:0] cnt;
   logic [3:0]    sum_r;
   logic          carry;
   logic          accept;
   logic          release_out;

   fadd_4 u_fadd (
      .a (acc),
      .b (in_data),
      .r (sum_r)
   );

   // A wrapped 4-bit sum is always smaller than the augend.
   assign carry       = (sum_r < acc);
   assign accept      = in_valid && in_ready;
   assign release_out = out_valid && out_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and state-decoded handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b1;
      out_valid = 1'b0;
      case (state)
         IDLE, ACC: begin
            // The accept that brings cnt to N closes the frame (covers N==1 from IDLE).
            if (accept) begin
               if (cnt == CW'(N - 1)) state_nxt = DONE;
               else                   state_nxt = ACC;
            end
         end
         DONE: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulator, carry counter and operand counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= 4'd0;
         carry_cnt <= 4'd0;
         cnt       <= '0;
      end else if (release_out) begin
         acc       <= 4'd0;
         carry_cnt <= 4'd0;
         cnt       <= '0;
      end else if (accept) begin
         acc       <= sum_r;
         carry_cnt <= carry_cnt + 4'(carry);
         cnt       <= cnt + CW'(1);
      end
   end

   assign out_total = {carry_cnt, acc};
   assign out_ovf   = (carry_cnt != 4'd0);

endmodule

// File: tb/tb_accum_frame.sv
module tb_accum_frame;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_total;
   logic       out_ovf;
   logic       out_valid;
   logic       out_ready;

   logic [3:0] in_data1;
   logic       in_valid1;
   logic       in_ready1;
   logic [7:0] out_total1;
   logic       out_ovf1;
   logic       out_valid1;
   logic       out_ready1;

   int checks = 0;
   int errors = 0;
   int unsigned ops[$];

   always #5 clk = ~clk;

   accum_frame #(.N(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_total(out_total), .out_ovf(out_ovf), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   accum_frame #(.N(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .out_total(out_total1), .out_ovf(out_ovf1), .out_valid(out_valid1),
      .out_ready(out_ready1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives the operands in ops (4 per frame) and checks the result against
   // the plain arithmetic sum. Called and returns on a falling edge.
   task automatic run_frame(input int bubbles, input bit ready_early, input int hold);
      int unsigned sum;
      logic [7:0]  exp_total;
      sum = 0;
      foreach (ops[i]) sum += ops[i];
      exp_total = 8'(sum);
      out_ready = ready_early;
      for (int i = 0; i < ops.size(); i++) begin
         chk("in_ready_idle_acc", 32'(in_ready), 32'd1);
         chk("no_early_out", 32'(out_valid), 32'd0);
         in_valid = 1'b1;
         in_data  = 4'(ops[i]);
         @(negedge clk);
         in_valid = 1'b0;
         if (i != ops.size() - 1) begin
            for (int b = 0; b < bubbles; b++) begin
               chk("bubble_no_out", 32'(out_valid), 32'd0);
               @(negedge clk);
            end
         end
      end
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_total", 32'(out_total), 32'(exp_total));
      chk("out_ovf", 32'(out_ovf), 32'(sum >= 16));
      chk("in_ready_done", 32'(in_ready), 32'd0);
      if (!ready_early && hold > 0) begin
         in_valid = 1'b1;
         in_data  = 4'd7;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_total_held", 32'(out_total), 32'(exp_total));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_out_valid", 32'(out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(in_ready), 32'd1);
      chk("post_hs_cleared", 32'(out_total), 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      in_data = 4'd0; in_valid = 1'b0; out_ready = 1'b0;
      in_data1 = 4'd0; in_valid1 = 1'b0; out_ready1 = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_total", 32'(out_total), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back, consumer ready throughout.
      ops = '{3, 5, 7, 9};
      run_frame(0, 1'b1, 0);
      // Four maximal operands: three wraps.
      ops = '{15, 15, 15, 15};
      run_frame(0, 1'b0, 0);
      // Bubbles between operands.
      ops = '{1, 2, 3, 4};
      run_frame(1, 1'b0, 0);
      // Backpressure for 5 cycles with a competing operand offered.
      ops = '{9, 9, 2, 6};
      run_frame(0, 1'b0, 5);

      // Reset mid-frame, asserted between edges.
      in_valid = 1'b1; in_data = 4'd8;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("partial_total", 32'(out_total), 32'h10);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_total", 32'(out_total), 32'd0);
      chk("midrst_ovf", 32'(out_ovf), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ops = '{1, 1, 1, 1};
      run_frame(0, 1'b0, 0);

      // Randomized frames.
      for (int f = 0; f < 8; f++) begin
         ops = {};
         for (int k = 0; k < 4; k++) ops.push_back($urandom_range(0, 15));
         run_frame(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      // N=1 build: single operand produces a result the next cycle.
      in_valid1 = 1'b1; in_data1 = 4'd9;
      @(negedge clk);
      in_valid1 = 1'b0;
      chk("n1_out_valid", 32'(out_valid1), 32'd1);
      chk("n1_out_total", 32'(out_total1), 32'h09);
      chk("n1_out_ovf", 32'(out_ovf1), 32'd0);
      chk("n1_in_ready", 32'(in_ready1), 32'd0);
      out_ready1 = 1'b1;
      @(negedge clk);
      chk("n1_post_hs", 32'(out_valid1), 32'd0);
      chk("n1_cleared", 32'(out_total1), 32'd0);
      out_ready1 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
